// File: rtl/dvp_pattern_tx.sv
// Parallel-camera-bus pattern transmitter.
// Emits complete frames (vsync, back porch, active lines, front porch) of
// 16-bit pixels, high byte first, on an 8-bit bus with href/vref framing.
// Every output is a flop that is loaded from the next-cycle position, so the
// bus changes on the edge that enters each position.
module dvp_pattern_tx #(
   parameter int WIDTH        = 640,
   parameter int HEIGHT       = 480,
   parameter int HBLANK       = 144,
   parameter int VSYNC_LINES  = 3,
   parameter int VBACK_LINES  = 17,
   parameter int VFRONT_LINES = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        en,
   input  logic [1:0]  mode,
   input  logic [15:0] const_pixel,
   output logic        href,
   output logic        vref,
   output logic [7:0]  digital,
   output logic        frame_done,
   output logic [7:0]  frame_cnt
);

   localparam int          LINE_CLKS   = 2 * WIDTH + HBLANK;
   localparam logic [11:0] LAST_COL    = 12'(LINE_CLKS - 1);
   localparam logic [11:0] ACT_COLS    = 12'(2 * WIDTH);
   localparam logic [9:0]  LAST_VSYNC  = 10'(VSYNC_LINES - 1);
   localparam logic [9:0]  LAST_VBACK  = 10'(VBACK_LINES - 1);
   localparam logic [9:0]  LAST_ACTIVE = 10'(HEIGHT - 1);
   localparam logic [9:0]  LAST_VFRONT = 10'(VFRONT_LINES - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_VSYNC  = 3'd1,
      ST_VBACK  = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_VFRONT = 3'd4
   } state_t;

   state_t      state_r, state_s;
   logic [11:0] col_r, col_s;
   logic [9:0]  line_r, line_s;
   logic [9:0]  last_line_s;
   logic        frame_end_s;   // current cycle is the last clock of a frame
   logic        start_s;       // this edge begins a new frame
   logic        done_next_s;   // next cycle is the last clock of a frame
   logic        href_s;

   // Frame-local copies, frozen for the whole frame at its start edge.
   logic [1:0]  mode_r;
   logic [15:0] const_r;
   logic [7:0]  cnt_lat_r;

   logic [7:0]  x_s;
   logic [7:0]  y_s;
   logic [15:0] pixel_s;
   logic [7:0]  byte_s;

   // Number of the last line in the current state.
   always_comb begin
      last_line_s = 10'd0;
      case (state_r)
         ST_VSYNC:  last_line_s = LAST_VSYNC;
         ST_VBACK:  last_line_s = LAST_VBACK;
         ST_ACTIVE: last_line_s = LAST_ACTIVE;
         ST_VFRONT: last_line_s = LAST_VFRONT;
         default:   last_line_s = 10'd0;
      endcase
   end

   // Next state and next column/line position.
   always_comb begin
      state_s     = state_r;
      col_s       = col_r;
      line_s      = line_r;
      frame_end_s = 1'b0;
      start_s     = 1'b0;
      if (state_r == ST_IDLE) begin
         col_s  = 12'd0;
         line_s = 10'd0;
         if (en) begin
            state_s = ST_VSYNC;
            start_s = 1'b1;
         end else begin
            state_s = ST_IDLE;
         end
      end else if (col_r != LAST_COL) begin
         col_s = col_r + 12'd1;
      end else if (line_r != last_line_s) begin
         col_s  = 12'd0;
         line_s = line_r + 10'd1;
      end else begin
         col_s  = 12'd0;
         line_s = 10'd0;
         case (state_r)
            ST_VSYNC:  state_s = ST_VBACK;
            ST_VBACK:  state_s = ST_ACTIVE;
            ST_ACTIVE: state_s = ST_VFRONT;
            ST_VFRONT: begin
               frame_end_s = 1'b1;
               if (en) begin
                  state_s = ST_VSYNC;
                  start_s = 1'b1;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            default:   state_s = ST_IDLE;
         endcase
      end
   end

   // Pixel pattern and byte selection for the position entered next cycle.
   always_comb begin
      x_s         = col_s[8:1];
      y_s         = line_s[7:0];
      href_s      = (state_s == ST_ACTIVE) && (col_s < ACT_COLS);
      done_next_s = (state_s == ST_VFRONT) && (col_s == LAST_COL) &&
                    (line_s == LAST_VFRONT);
      pixel_s     = 16'h0000;
      case (mode_r)
         2'd0:    pixel_s = {x_s, y_s};
         2'd1:    pixel_s = const_r;
         2'd2:    pixel_s = (x_s[3] ^ y_s[3] ^ cnt_lat_r[0]) ? 16'hFFFF : 16'h0000;
         2'd3:    pixel_s = {cnt_lat_r, cnt_lat_r};
         default: pixel_s = 16'h0000;
      endcase
      if (col_s[0]) begin
         byte_s = pixel_s[7:0];
      end else begin
         byte_s = pixel_s[15:8];
      end
   end

   // State and position counters.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
         col_r   <= 12'd0;
         line_r  <= 10'd0;
      end else begin
         state_r <= state_s;
         col_r   <= col_s;
         line_r  <= line_s;
      end
   end

   // Registered bus outputs and frame completion counter.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         href       <= 1'b0;
         vref       <= 1'b0;
         digital    <= 8'h00;
         frame_done <= 1'b0;
         frame_cnt  <= 8'd0;
      end else begin
         href       <= href_s;
         vref       <= (state_s == ST_VSYNC);
         digital    <= href_s ? byte_s : 8'h00;
         frame_done <= done_next_s;
         if (frame_end_s) begin
            frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end

   // Frame-start latch of pattern inputs; the count includes a frame
   // completing on this very edge.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mode_r    <= 2'd0;
         const_r   <= 16'h0000;
         cnt_lat_r <= 8'd0;
      end else if (start_s) begin
         mode_r    <= mode;
         const_r   <= const_pixel;
         cnt_lat_r <= frame_end_s ? (frame_cnt + 8'd1) : frame_cnt;
      end
   end

endmodule

// File: tb/tb_dvp_pattern_tx.sv
// Bench for dvp_pattern_tx with a small frame (LINE_CLKS=12, frame=60 clocks).
// Stimulus pushes the expected active bytes of each frame into a queue when
// that frame's settings are issued; a negedge monitor pops and compares every
// byte presented with href=1 and checks blanking on all other cycles.
module tb_dvp_pattern_tx;

   localparam int W  = 4;
   localparam int H  = 2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        en = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [15:0] const_pixel = 16'h0000;
   logic        href, vref, frame_done;
   logic [7:0]  digital, frame_cnt;

   int          total = 0;
   int          bad = 0;
   logic [7:0]  exp_q[$];

   dvp_pattern_tx #(
      .WIDTH(4), .HEIGHT(2), .HBLANK(4),
      .VSYNC_LINES(1), .VBACK_LINES(1), .VFRONT_LINES(1)
   ) dut (
      .clk(clk), .reset_n(reset_n), .en(en), .mode(mode),
      .const_pixel(const_pixel), .href(href), .vref(vref),
      .digital(digital), .frame_done(frame_done), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected active bytes of one frame, straight from the pattern definitions.
   task automatic push_frame(input logic [1:0] m, input logic [15:0] cp, input logic [7:0] cnt);
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            logic [7:0]  xb;
            logic [7:0]  yb;
            logic [15:0] p;
            xb = 8'(x);
            yb = 8'(y);
            case (m)
               2'd0:    p = {xb, yb};
               2'd1:    p = cp;
               2'd2:    p = (xb[3] ^ yb[3] ^ cnt[0]) ? 16'hFFFF : 16'h0000;
               default: p = {cnt, cnt};
            endcase
            exp_q.push_back(p[15:8]);
            exp_q.push_back(p[7:0]);
         end
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic adv_n(input int n);
      for (int i = 0; i < n; i++) adv();
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (href === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_byte: got %0h expected no active byte", digital);
         end else begin
            chk("active_byte", {24'd0, digital}, {24'd0, exp_q.pop_front()});
         end
      end else begin
         chk("blank_byte", {24'd0, digital}, 32'd0);
      end
      chk("href_vref_excl", {31'd0, href & vref}, 32'd0);
   end

   initial begin
      // Reset and idle
      reset_n = 1'b0;
      en = 1'b0;
      adv_n(3);
      reset_n = 1'b1;
      for (int i = 0; i < 100; i++) begin
         adv();
         chk("idle_outputs", {13'd0, href, vref, digital, frame_done, frame_cnt}, 32'd0);
      end

      // Sync timing with mode 0; mode 1 A55A requested mid-frame for frame 1
      mode = 2'd0;
      en = 1'b1;
      push_frame(2'd0, 16'h0000, 8'd0);
      for (int j = 1; j <= 61; j++) begin
         adv();
         chk("vref_timing", {31'd0, vref}, {31'd0, (j <= 12) || (j == 61)});
         chk("href_timing", {31'd0, href}, {31'd0, (j >= 25 && j <= 32) || (j >= 37 && j <= 44)});
         chk("frame_done_timing", {31'd0, frame_done}, {31'd0, j == 60});
         if (j == 30) begin
            mode = 2'd1;
            const_pixel = 16'hA55A;
            push_frame(2'd1, 16'hA55A, 8'd1);
         end
         if (j == 60) chk("frame_cnt_before", {24'd0, frame_cnt}, 32'd0);
         if (j == 61) chk("frame_cnt_after", {24'd0, frame_cnt}, 32'd1);
      end

      // Frame 1 (A55A): const changes mid-frame, taking effect in frame 2
      adv_n(19);
      const_pixel = 16'h1234;
      push_frame(2'd1, 16'h1234, 8'd2);
      adv_n(40);

      // Frame 2: drop en during active line 0; frame completes then idles
      adv_n(27);
      en = 1'b0;
      for (int j = 28; j <= 61; j++) begin
         adv();
         chk("stop_frame_done", {31'd0, frame_done}, {31'd0, j == 60});
         if (j == 61) chk("stop_frame_cnt", {24'd0, frame_cnt}, 32'd3);
      end
      for (int i = 0; i < 30; i++) begin
         adv();
         chk("stopped_idle", {22'd0, href, vref, digital}, 32'd0);
         chk("stopped_cnt", {24'd0, frame_cnt, frame_done}, {24'd0, 8'd3, 1'b0} >> 0);
      end

      // Mode 3 across frames 0 and 1
      reset_n = 1'b0;
      adv_n(3);
      chk("reset_cnt", {24'd0, frame_cnt}, 32'd0);
      reset_n = 1'b1;
      mode = 2'd3;
      en = 1'b1;
      push_frame(2'd3, 16'h0000, 8'd0);
      adv_n(30);
      push_frame(2'd3, 16'h0000, 8'd1);
      adv_n(60);
      en = 1'b0;
      adv_n(30);
      chk("mode3_done", {31'd0, frame_done}, 32'd1);
      adv();
      chk("mode3_cnt", {24'd0, frame_cnt}, 32'd2);

      // Mode 2 across frames 0 and 1, then reset mid-active-line
      reset_n = 1'b0;
      adv_n(3);
      reset_n = 1'b1;
      mode = 2'd2;
      en = 1'b1;
      push_frame(2'd2, 16'h0000, 8'd0);
      adv_n(30);
      push_frame(2'd2, 16'h0000, 8'd1);
      adv_n(58);
      chk("pre_reset_href", {31'd0, href}, 32'd1);
      reset_n = 1'b0;
      adv();
      chk("reset_href", {31'd0, href}, 32'd0);
      chk("reset_digital", {24'd0, digital}, 32'd0);
      chk("reset_frame_cnt", {24'd0, frame_cnt}, 32'd0);
      exp_q.delete();
      en = 1'b0;
      adv_n(2);
      reset_n = 1'b1;
      for (int i = 0; i < 70; i++) begin
         adv();
         chk("post_reset_idle", {13'd0, href, vref, digital, frame_done, frame_cnt}, 32'd0);
      end

      chk("queue_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
